// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Shares the single-port 1024x32 BRAM `Memory` between the two requesters of
// the multicycle RV32I core: instruction fetch (IF) and load/store (D).
// Byte addresses become word addresses. Byte and halfword stores are done as
// read-modify-write. Misaligned data accesses are flagged instead of performed.
//
// Ports:
//   clk_i, reset_i        clock (posedge) and synchronous active-high reset
//   if_req_i/if_addr_i    fetch request, byte address (bits [1:0] ignored)
//   if_ack_o/if_data_o    one-cycle completion pulse, fetched word (held)
//   d_req_i/d_we_i        data request, 1 = store / 0 = load
//   d_size_i              00 byte, 01 half, 10/11 word
//   d_addr_i/d_wdata_i    data byte address, right-justified store data
//   d_ack_o/d_err_o       one-cycle completion pulse, misaligned flag
//   d_rdata_o             raw aligned word for loads
//   mem_addr_o            word address to `Memory`
//   mem_data_o            write data to `Memory`
//   mem_wr_n_o/mem_rd_n_o active-low strobes, sampled by `Memory` on negedge
//   mem_data_i            `Memory` read data
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int WORDS      = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  if_req_i,
    input  logic [31:0]           if_addr_i,
    output logic                  if_ack_o,
    output logic [DATA_WIDTH-1:0] if_data_o,
    input  logic                  d_req_i,
    input  logic                  d_we_i,
    input  logic [1:0]            d_size_i,
    input  logic [31:0]           d_addr_i,
    input  logic [DATA_WIDTH-1:0] d_wdata_i,
    output logic                  d_ack_o,
    output logic                  d_err_o,
    output logic [DATA_WIDTH-1:0] d_rdata_o,
    output logic [WORDS-1:0]      mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_data_o,
    output logic                  mem_wr_n_o,
    output logic                  mem_rd_n_o,
    input  logic [DATA_WIDTH-1:0] mem_data_i
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR,
        RMW_RD,
        RMW_WR,
        ACK
    } state_t;

    state_t                state;
    logic                  last_grant_d;
    logic                  serving_d;
    logic                  grant_if;
    logic                  grant_d;
    logic                  d_word;
    logic                  d_half;
    logic                  d_misaligned;
    logic [DATA_WIDTH-1:0] merged;
    logic                  unused_addr_bits;

    // Address bits above the memory depth wrap, and fetch lane bits are
    // meaningless for whole-word fetches.
    assign unused_addr_bits = ^{if_addr_i[31:WORDS+2], if_addr_i[1:0],
                                d_addr_i[31:WORDS+2]};

    // Size 11 behaves as a word access.
    assign d_word       = d_size_i[1];
    assign d_half       = (d_size_i == 2'b01);
    assign d_misaligned = (d_half && d_addr_i[0]) ||
                          (d_word && (d_addr_i[1:0] != 2'b00));

    // Round-robin arbitration: a lone requester always wins; on a tie the
    // requester that was not granted last time goes first. Only consulted
    // in IDLE.
    always_comb begin
        grant_if = 1'b0;
        grant_d  = 1'b0;
        if (if_req_i && d_req_i) begin
            if (last_grant_d) begin
                grant_if = 1'b1;
            end else begin
                grant_d = 1'b1;
            end
        end else if (if_req_i) begin
            grant_if = 1'b1;
        end else if (d_req_i) begin
            grant_d = 1'b1;
        end
    end

    // Little-endian merge of a sub-word store into the word just read back.
    // Only byte and half stores reach the RMW path, so anything that is not
    // a half is a byte here.
    always_comb begin
        merged = mem_data_i;
        if (d_half) begin
            if (d_addr_i[1]) begin
                merged[31:16] = d_wdata_i[15:0];
            end else begin
                merged[15:0] = d_wdata_i[15:0];
            end
        end else begin
            case (d_addr_i[1:0])
                2'b00:   merged[7:0]   = d_wdata_i[7:0];
                2'b01:   merged[15:8]  = d_wdata_i[7:0];
                2'b10:   merged[23:16] = d_wdata_i[7:0];
                default: merged[31:24] = d_wdata_i[7:0];
            endcase
        end
    end

    // Main sequencer. Strobes are registered and held low for exactly one
    // cycle so the memory sees them on the following negedge; read data is
    // then stable at the next posedge. Every access passes through ACK, where
    // no grant is made, so a requester still holding req is not served twice
    // and at least one IDLE cycle separates consecutive accesses.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state        <= IDLE;
            last_grant_d <= 1'b1;
            serving_d    <= 1'b0;
            mem_rd_n_o   <= 1'b1;
            mem_wr_n_o   <= 1'b1;
            mem_addr_o   <= '0;
            mem_data_o   <= '0;
            if_data_o    <= '0;
            d_rdata_o    <= '0;
            if_ack_o     <= 1'b0;
            d_ack_o      <= 1'b0;
            d_err_o      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_if) begin
                        last_grant_d <= 1'b0;
                        serving_d    <= 1'b0;
                        mem_addr_o   <= if_addr_i[WORDS+1:2];
                        mem_rd_n_o   <= 1'b0;
                        state        <= RD;
                    end else if (grant_d) begin
                        last_grant_d <= 1'b1;
                        serving_d    <= 1'b1;
                        mem_addr_o   <= d_addr_i[WORDS+1:2];
                        if (d_misaligned) begin
                            d_ack_o <= 1'b1;
                            d_err_o <= 1'b1;
                            state   <= ACK;
                        end else if (!d_we_i) begin
                            mem_rd_n_o <= 1'b0;
                            state      <= RD;
                        end else if (d_word) begin
                            mem_wr_n_o <= 1'b0;
                            mem_data_o <= d_wdata_i;
                            state      <= WR;
                        end else begin
                            mem_rd_n_o <= 1'b0;
                            state      <= RMW_RD;
                        end
                    end
                end
                RD: begin
                    mem_rd_n_o <= 1'b1;
                    if (serving_d) begin
                        d_rdata_o <= mem_data_i;
                        d_ack_o   <= 1'b1;
                    end else begin
                        if_data_o <= mem_data_i;
                        if_ack_o  <= 1'b1;
                    end
                    state <= ACK;
                end
                WR: begin
                    mem_wr_n_o <= 1'b1;
                    d_ack_o    <= 1'b1;
                    state      <= ACK;
                end
                RMW_RD: begin
                    mem_rd_n_o <= 1'b1;
                    mem_data_o <= merged;
                    mem_wr_n_o <= 1'b0;
                    state      <= RMW_WR;
                end
                RMW_WR: begin
                    mem_wr_n_o <= 1'b1;
                    d_ack_o    <= 1'b1;
                    state      <= ACK;
                end
                ACK: begin
                    if_ack_o <= 1'b0;
                    d_ack_o  <= 1'b0;
                    d_err_o  <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    mem_rd_n_o <= 1'b1;
                    mem_wr_n_o <= 1'b1;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//
// Drives mem_arbiter against a behavioural model of the negedge-sampled
// 1024x32 `Memory`, and predicts every transaction (data, latency, strobe
// counts, final memory word, grant order) from a word-array reference model.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_ack_o;
    logic [31:0] if_data_o;
    logic        d_req_i;
    logic        d_we_i;
    logic [1:0]  d_size_i;
    logic [31:0] d_addr_i;
    logic [31:0] d_wdata_i;
    logic        d_ack_o;
    logic        d_err_o;
    logic [31:0] d_rdata_o;
    logic [9:0]  mem_addr_o;
    logic [31:0] mem_data_o;
    logic        mem_wr_n_o;
    logic        mem_rd_n_o;
    logic [31:0] mem_data_i = '0;

    logic [31:0] tb_mem  [0:1023];
    logic [31:0] ref_mem [0:1023];
    int          rd_cnt    = 0;
    int          wr_cnt    = 0;
    int          last_addr = 0;
    int          total     = 0;
    int          passed    = 0;
    int          failed    = 0;
    logic [31:0] last_if   = '0;
    bit          last_is_d = 1'b1;

    mem_arbiter #(
        .WORDS      (10),
        .DATA_WIDTH (32)
    ) dut (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .if_req_i   (if_req_i),
        .if_addr_i  (if_addr_i),
        .if_ack_o   (if_ack_o),
        .if_data_o  (if_data_o),
        .d_req_i    (d_req_i),
        .d_we_i     (d_we_i),
        .d_size_i   (d_size_i),
        .d_addr_i   (d_addr_i),
        .d_wdata_i  (d_wdata_i),
        .d_ack_o    (d_ack_o),
        .d_err_o    (d_err_o),
        .d_rdata_o  (d_rdata_o),
        .mem_addr_o (mem_addr_o),
        .mem_data_o (mem_data_o),
        .mem_wr_n_o (mem_wr_n_o),
        .mem_rd_n_o (mem_rd_n_o),
        .mem_data_i (mem_data_i)
    );

    // 100 MHz clock.
    always #5 clk_i = ~clk_i;

    // Power-up contents shared by the memory model and the reference model,
    // with the words the directed steps rely on pinned to known values.
    function automatic logic [31:0] init_word(input int i);
        logic [31:0] w;
        w = (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;
        if (i == 5)  w = 32'h1111000B;
        if (i == 10) w = 32'h55AA3312;
        if (i == 14) w = 32'hBBAA1136;
        return w;
    endfunction

    // Behavioural `Memory`: strobes are sampled on the negedge, reads land on
    // data_o right away. Strobe counts and the last strobed address let the
    // bench see how the arbiter drove the array.
    initial begin
        for (int i = 0; i < 1024; i++) tb_mem[i] = init_word(i);
        forever begin
            @(negedge clk_i);
            if (!mem_rd_n_o) begin
                mem_data_i <= tb_mem[mem_addr_o];
                rd_cnt     <= rd_cnt + 1;
                last_addr  <= int'(mem_addr_o);
            end
            if (!mem_wr_n_o) begin
                tb_mem[mem_addr_o] <= mem_data_o;
                wr_cnt             <= wr_cnt + 1;
                last_addr          <= int'(mem_addr_o);
            end
        end
    end

    // One comparison: counted, asserted, reported on failure.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected) passed++;
        else begin
            failed++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // One complete transaction from a single requester, started on a negedge
    // while the arbiter is idle. The expected outcome is worked out from the
    // access rules on the reference word array before anything is driven.
    task automatic applyStimulus(input bit is_d, input bit we, input logic [1:0] size,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        int          wi;
        bit          mis;
        int          sh;
        int          exp_lat;
        int          exp_rd;
        int          exp_wr;
        int          lat;
        int          rd0;
        int          wr0;
        logic [31:0] mask;
        logic [31:0] old_word;
        logic [31:0] new_word;

        wi       = int'(addr[11:2]);
        mis      = is_d && ((size == 2'b01 && addr[0]) || (size[1] && addr[1:0] != 2'b00));
        old_word = ref_mem[wi];
        new_word = old_word;
        if (is_d && we && !mis) begin
            if (size[1]) begin
                new_word = wdata;
            end else if (size == 2'b01) begin
                sh       = addr[1] ? 16 : 0;
                mask     = 32'h0000FFFF << sh;
                new_word = (old_word & ~mask) | ((wdata & 32'h0000FFFF) << sh);
            end else begin
                sh       = 8 * int'(addr[1:0]);
                mask     = 32'h000000FF << sh;
                new_word = (old_word & ~mask) | ((wdata & 32'h000000FF) << sh);
            end
        end
        if (mis)                        exp_lat = 1;
        else if (is_d && we && !size[1]) exp_lat = 3;
        else                             exp_lat = 2;
        exp_rd = (mis || (is_d && we && size[1])) ? 0 : 1;
        exp_wr = (is_d && we && !mis) ? 1 : 0;

        rd0 = rd_cnt;
        wr0 = wr_cnt;
        if (is_d) begin
            d_req_i   = 1'b1;
            d_we_i    = we;
            d_size_i  = size;
            d_addr_i  = addr;
            d_wdata_i = wdata;
        end else begin
            if_req_i  = 1'b1;
            if_addr_i = addr;
        end

        lat = 0;
        do begin
            @(negedge clk_i);
            lat++;
        end while (!(is_d ? d_ack_o : if_ack_o) && lat < 8);

        checkOutput("latency", lat, exp_lat);
        checkOutput("ack_excl", {31'b0, (is_d ? if_ack_o : d_ack_o)}, 32'd0);
        checkOutput("rd_strobes", rd_cnt - rd0, exp_rd);
        checkOutput("wr_strobes", wr_cnt - wr0, exp_wr);
        if (exp_rd + exp_wr != 0) checkOutput("mem_addr", last_addr, wi);
        if (is_d) begin
            checkOutput("d_err", {31'b0, d_err_o}, {31'b0, mis});
            checkOutput("if_hold", if_data_o, last_if);
            if (!we && !mis) checkOutput("d_rdata", d_rdata_o, old_word);
        end else begin
            checkOutput("if_data", if_data_o, old_word);
            last_if = old_word;
        end
        checkOutput("mem_word", tb_mem[wi], new_word);
        ref_mem[wi] = new_word;
        last_is_d   = is_d;

        if_req_i = 1'b0;
        d_req_i  = 1'b0;
        @(negedge clk_i);
        checkOutput("ack_pulse", {30'b0, if_ack_o, d_ack_o}, 32'd0);
    endtask

    initial begin
        bit          exp_d;
        bit          seen;
        int          n;
        int          wr0;
        bit          r_is_d;
        bit          r_we;
        logic [1:0]  r_size;
        logic [31:0] r_addr;

        for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
        reset_i   = 1'b1;
        if_req_i  = 1'b0;
        if_addr_i = '0;
        d_req_i   = 1'b0;
        d_we_i    = 1'b0;
        d_size_i  = 2'b00;
        d_addr_i  = '0;
        d_wdata_i = '0;
        $display("[TB] reset");
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        checkOutput("rst_rd_n", {31'b0, mem_rd_n_o}, 32'd1);
        checkOutput("rst_wr_n", {31'b0, mem_wr_n_o}, 32'd1);
        checkOutput("rst_mem_addr", 32'(mem_addr_o), 32'd0);
        checkOutput("rst_mem_data", mem_data_o, 32'd0);
        checkOutput("rst_if_data", if_data_o, 32'd0);
        checkOutput("rst_d_rdata", d_rdata_o, 32'd0);
        checkOutput("rst_acks_err", {29'b0, if_ack_o, d_ack_o, d_err_o}, 32'd0);
        reset_i = 1'b0;

        $display("[TB] directed accesses");
        applyStimulus(1'b0, 1'b0, 2'b00, 32'h0000_0014, 32'h0);
        checkOutput("if_read_value", if_data_o, 32'h1111000B);
        applyStimulus(1'b1, 1'b1, 2'b10, 32'h0000_0058, 32'hDEADBEEF);
        checkOutput("word_store_value", tb_mem[22], 32'hDEADBEEF);
        applyStimulus(1'b1, 1'b0, 2'b10, 32'h0000_0058, 32'h0);
        applyStimulus(1'b1, 1'b1, 2'b00, 32'h0000_002A, 32'h0000007E);
        checkOutput("byte_rmw_value", tb_mem[10], 32'h557E3312);
        applyStimulus(1'b1, 1'b1, 2'b01, 32'h0000_003A, 32'h0000BEEF);
        checkOutput("half_rmw_value", tb_mem[14], 32'hBEEF1136);
        applyStimulus(1'b1, 1'b0, 2'b10, 32'h0000_0052, 32'h0);
        applyStimulus(1'b1, 1'b1, 2'b01, 32'h0000_0041, 32'h12345678);
        applyStimulus(1'b1, 1'b1, 2'b11, 32'h0000_1060, 32'hCAFEF00D);

        $display("[TB] reset during read-modify-write");
        wr0       = wr_cnt;
        d_req_i   = 1'b1;
        d_we_i    = 1'b1;
        d_size_i  = 2'b00;
        d_addr_i  = 32'h0000_0031;
        d_wdata_i = 32'h000000A5;
        @(negedge clk_i);
        checkOutput("rmw_rd_strobe", {31'b0, mem_rd_n_o}, 32'd0);
        reset_i = 1'b1;
        @(negedge clk_i);
        checkOutput("rst_mid_strobes", {30'b0, mem_rd_n_o, mem_wr_n_o}, 32'd3);
        checkOutput("rst_mid_ack", {30'b0, if_ack_o, d_ack_o}, 32'd0);
        reset_i = 1'b0;
        d_req_i = 1'b0;
        seen    = 1'b0;
        repeat (4) begin
            @(negedge clk_i);
            if (if_ack_o || d_ack_o) seen = 1'b1;
        end
        checkOutput("rst_no_ack", {31'b0, seen}, 32'd0);
        checkOutput("rst_no_write", wr_cnt - wr0, 32'd0);
        checkOutput("rst_word_kept", tb_mem[12], ref_mem[12]);
        checkOutput("rst_if_cleared", if_data_o, 32'd0);
        last_is_d = 1'b1;
        last_if   = '0;

        $display("[TB] contention");
        if_req_i  = 1'b1;
        if_addr_i = 32'h0000_0014;
        d_req_i   = 1'b1;
        d_we_i    = 1'b0;
        d_size_i  = 2'b10;
        d_addr_i  = 32'h0000_0028;
        exp_d     = !last_is_d;
        for (int g = 0; g < 4; g++) begin
            n = 0;
            do begin
                @(negedge clk_i);
                n++;
            end while (!(if_ack_o || d_ack_o) && n < 12);
            checkOutput("cont_excl", {31'b0, if_ack_o & d_ack_o}, 32'd0);
            checkOutput("cont_who", {31'b0, d_ack_o}, {31'b0, exp_d});
            checkOutput("cont_gap", n, (g == 0) ? 2 : 3);
            if (exp_d) begin
                checkOutput("cont_d_data", d_rdata_o, ref_mem[10]);
            end else begin
                checkOutput("cont_if_data", if_data_o, ref_mem[5]);
                last_if = ref_mem[5];
            end
            last_is_d = exp_d;
            exp_d     = !exp_d;
        end
        if_req_i = 1'b0;
        d_req_i  = 1'b0;
        @(negedge clk_i);
        checkOutput("cont_idle", {30'b0, if_ack_o, d_ack_o}, 32'd0);

        $display("[TB] randomized accesses");
        for (int k = 0; k < 60; k++) begin
            r_is_d = ($urandom_range(0, 2) != 0);
            r_we   = 1'($urandom_range(0, 1));
            r_size = 2'($urandom_range(0, 3));
            r_addr = $urandom();
            if ($urandom_range(0, 3) != 0) begin
                if (r_size[1])            r_addr[1:0] = 2'b00;
                else if (r_size == 2'b01) r_addr[0]   = 1'b0;
            end
            applyStimulus(r_is_d, r_we, r_size, r_addr, $urandom());
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Backstop so a wedged run still ends.
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout observed=running expected=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences and shares the single-port 1024x32 BRAM `Memory` between two requesters of the multicycle RV32I core: instruction fetch (IF) and load/store (D).
- Drives the memory's active-low, negedge-sampled `rd_i`/`wr_i` strobes.
- Converts byte addresses to word addresses.
- Implements byte and halfword stores as read-modify-write (RMW).
- Flags misaligned data accesses.

Parameters:
- WORDS, 10, log2 of memory depth in 32-bit words; must match the `Memory` instance.
- DATA_WIDTH, 32, memory word width; only 32 is supported.

Ports:
- clk_i  in  1  clock; all logic on posedge.
- reset_i  in  1  synchronous, active-high reset.
- if_req_i  in  1  fetch request; held high until if_ack_o.
- if_addr_i  in  32  fetch byte address; bits [1:0] ignored.
- if_ack_o  out  1  one-cycle completion pulse.
- if_data_o  out  32  fetched word; valid while if_ack_o is high and held until the next IF ack.
- d_req_i  in  1  data request; held high until d_ack_o.
- d_we_i  in  1  1 = store, 0 = load.
- d_size_i  in  2  00 = byte, 01 = half, 10 = word; 11 is treated as word.
- d_addr_i  in  32  data byte address.
- d_wdata_i  in  32  store data, right-justified.
- d_ack_o  out  1  one-cycle completion pulse.
- d_err_o  out  1  misaligned access; valid with d_ack_o.
- d_rdata_o  out  32  raw aligned word for loads; lane extraction is done by the core.
- mem_addr_o  out  WORDS  word address to `Memory`.
- mem_data_o  out  32  write data to `Memory`.
- mem_wr_n_o  out  1  active-low write strobe.
- mem_rd_n_o  out  1  active-low read strobe.
- mem_data_i  in  32  `Memory` data_o.

Behaviour:
- **Reset values:**
  - state = IDLE; mem_rd_n_o = 1, mem_wr_n_o = 1.
  - mem_addr_o, mem_data_o, if_data_o, d_rdata_o = 0.
  - Both acks and d_err_o = 0; last_grant = D, so IF wins the first tie.
- **Memory timing:**
  - A strobe driven low from posedge E is sampled by the memory at the following negedge.
  - Read data is therefore stable at posedge E+1.
  - Strobes are low for exactly one cycle per access.
- **Word address:** mem_addr_o = addr[WORDS+1:2]. Upper bits are ignored, so addresses wrap modulo 4 KiB.
- **Arbitration:**
  - Decided in IDLE only.
  - With a single requester, that requester is granted.
  - With both requesting, the requester not named by last_grant is granted (alternating round-robin).
  - last_grant updates on each grant.
- **States:** IDLE, RD, WR, RMW_RD, RMW_WR, ACK.
  - IDLE → RD: IF grant, or D load; mem_rd_n_o = 0.
  - IDLE → WR: D word store; mem_wr_n_o = 0, mem_data_o = d_wdata_i.
  - IDLE → RMW_RD: D byte/half store; mem_rd_n_o = 0.
  - IDLE → ACK: D misaligned access (half with addr[0] = 1, or word with addr[1:0] ≠ 0).
    - No memory strobe is asserted.
    - d_ack_o = 1 and d_err_o = 1 in the ACK cycle.
  - RD → ACK: capture mem_data_i into if_data_o or d_rdata_o; pulse the granted ack; rd_n returns to 1.
  - WR → ACK: wr_n returns to 1; pulse d_ack_o.
  - RMW_RD → RMW_WR: merge and write back with mem_wr_n_o = 0.
    - Byte: replace lane addr[1:0], bits [8*lane+:8], with d_wdata_i[7:0].
    - Half: replace bits [16*addr[1]+:16] with d_wdata_i[15:0].
    - Little-endian.
  - RMW_WR → ACK: pulse d_ack_o.
  - ACK → IDLE: unconditional. No grant is made in ACK, so a still-high req is not re-served.
- **Latency** (grant edge E0 to ack-high cycle):
  - Read or word store: ack high after E1.
  - Sub-word store: ack high after E2.
  - Misaligned: ack high after E0.
  - A new grant can occur at the edge ending the IDLE cycle that follows ACK.
- d_err_o is 0 on every non-error ack. Acks are mutually exclusive.
- Inputs (address, size, write data, we) are sampled only at the grant edge and at the RMW merge edge. Requesters must hold them stable until ack.
- **Reset mid-operation:**
  - Reset at any edge forces IDLE with strobes high; no ack is issued.
  - A write whose strobe was low across a negedge is already committed.
  - A reset between RMW_RD and RMW_WR leaves memory unmodified.
- A request dropped before ack is undefined usage; the controller still completes the access and pulses ack.

Test Plan:
- **IF read:** mem[5] = 0x1111000B; if_req with if_addr = 0x14 → mem_rd_n low for 1 cycle with mem_addr = 5; if_ack one cycle later with if_data = 0x1111000B.
- **Word store:** d_we = 1, size = 10, addr = 0x58, wdata = 0xDEADBEEF → mem_wr_n low one cycle with addr 0x16; d_ack; readback word = 0xDEADBEEF.
- **Byte RMW:** mem[10] = 0x55AA3312; store byte 0x7E at addr 0x2A → mem[10] = 0x557E3312 after 2 cycles; d_ack; wr_n low exactly once.
- **Half RMW:** store 0xBEEF at addr 0x3A on mem[14] = 0xBBAA1136 → 0xBEEF1136.
- **Contention:** IF and D requesting continuously → grants IF, D, IF, D; acks never overlap; each ack followed by one IDLE cycle.
- **Misaligned and reset:**
  - Word load at 0x52 → d_ack and d_err the cycle after grant, no strobe.
  - Reset asserted in RMW_RD → strobes high, no ack, target word unchanged.
